lcd_spi_monitor: RTL and testbench

- Receive-side model of the PCD8544-style serial LCD link (mosi/sclk/ce/dc/lcd_rst) driven by the pet display driver.
- Oversamples the link on clk, deframes bytes, decodes the command set, and maintains a shadow 84x6-byte display RAM plus controller status.
- Used in loopback/self-check builds and as the bench scoreboard source: anything the driver sends becomes readable frame content.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_spi_deframer.sv | 81 ++++++++
 rtl/lcd_spi_monitor.sv | 137 +++++++++++++
 tb/tb_lcd_spi_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the serial LCD link monitor.
// Geometry, shadow-RAM address width and command opcode masks/patterns.
// Also holds the controller status record and an opcode match helper.
package lcd_pkg;

    localparam int COLS   = 84;
    localparam int ROWS   = 6;
    localparam int ADDR_W = 9;

    // Opcode classes: a byte belongs to a class when (byte & MASK) == PAT.
    localparam logic [7:0] FUNC_SET_MASK  = 8'hF8;
    localparam logic [7:0] FUNC_SET_PAT   = 8'h20;
    localparam logic [7:0] DISP_CTRL_MASK = 8'hFA;
    localparam logic [7:0] DISP_CTRL_PAT  = 8'h08;
    localparam logic [7:0] SET_Y_MASK     = 8'hF8;
    localparam logic [7:0] SET_Y_PAT      = 8'h40;
    localparam logic [7:0] SET_X_MASK     = 8'h80;
    localparam logic [7:0] SET_X_PAT      = 8'h80;
    localparam logic [7:0] TEMP_CTRL_MASK = 8'hFC;
    localparam logic [7:0] TEMP_CTRL_PAT  = 8'h04;
    localparam logic [7:0] BIAS_MASK      = 8'hF8;
    localparam logic [7:0] BIAS_PAT       = 8'h10;
    localparam logic [7:0] VOP_MASK       = 8'h80;
    localparam logic [7:0] VOP_PAT        = 8'h80;

    typedef struct packed {
        logic [6:0] x;
        logic [2:0] y;
        logic       pd;
        logic       v;
        logic       h;
        logic [1:0] disp_mode;
        logic [6:0] vop;
    } status_t;

    function automatic logic op_match(input logic [7:0] b,
                                      input logic [7:0] mask,
                                      input logic [7:0] pat);
        return (b & mask) == pat;
    endfunction

endpackage

// File: rtl/lcd_spi_deframer.sv
// Purpose: synchronise the serial LCD link, detect sclk rises, assemble bytes.
// Latency: byte_valid one cycle after the edge-detect cycle of the 8th sclk rise.
// Backpressure: none; bytes are presented once as a one-cycle pulse.
// Ports: clk/reset; raw link inputs mosi/sclk/ce/dc/lcd_rst; byte_valid,
// byte_out, byte_dc, frag_err pulses; lcd_rst_sync is the synchronised lcd_rst.
module lcd_spi_deframer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mosi,
    input  logic       sclk,
    input  logic       ce,
    input  logic       dc,
    input  logic       lcd_rst,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_dc,
    output logic       frag_err,
    output logic       lcd_rst_sync
);

    // Bit order {lcd_rst, ce, dc, sclk, mosi}. The chain resets to the idle
    // link (ce and lcd_rst deasserted) so leaving reset causes no LCD reset.
    localparam logic [4:0] SYNC_IDLE = 5'b11000;

    logic [4:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
        end else begin
            sync_q[0] <= {lcd_rst, ce, dc, sclk, mosi};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic mosi_s, sclk_s, dc_s, ce_s;
    assign {lcd_rst_sync, ce_s, dc_s, sclk_s, mosi_s} = sync_q[SYNC_STAGES-1];

    logic       sclk_prev;
    logic       sclk_rise;
    logic [7:0] shift_q;
    logic [2:0] bitcnt;

    assign sclk_rise = sclk_s & ~sclk_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_prev  <= 1'b0;
            shift_q    <= '0;
            bitcnt     <= '0;
            byte_out   <= '0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
            frag_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frag_err   <= 1'b0;
            sclk_prev  <= sclk_s;
            // LCD reset outranks everything, including a coinciding 8th bit.
            if (!lcd_rst_sync) begin
                bitcnt  <= '0;
                shift_q <= '0;
            end else if (ce_s) begin
                if (bitcnt != 3'd0) frag_err <= 1'b1;
                bitcnt  <= '0;
                shift_q <= '0;
            end else if (sclk_rise) begin
                shift_q <= {shift_q[6:0], mosi_s};
                bitcnt  <= bitcnt + 3'd1;   // 7 -> 0 closes the byte
                if (bitcnt == 3'd7) begin
                    byte_out   <= {shift_q[6:0], mosi_s};
                    byte_dc    <= dc_s;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_monitor.sv
// Purpose: receive-side LCD link model: decode commands, keep shadow RAM + status.
// Latency: status/RAM update on the byte_valid cycle; rd_data one cycle after rd_addr.
// Backpressure: none; one byte per 8 sclk periods is absorbed unconditionally.
// Ports: clk/reset; link inputs mosi/sclk/ce/dc/lcd_rst; byte_valid/byte_out/
// byte_dc/frag_err byte stream; rd_addr/rd_data RAM port; cur_x/cur_y, pd/v/h,
// disp_mode, vop status; frame_done pulse on a data write to the last address.
module lcd_spi_monitor #(
    parameter int COLS        = lcd_pkg::COLS,
    parameter int ROWS        = lcd_pkg::ROWS,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mosi,
    input  logic       sclk,
    input  logic       ce,
    input  logic       dc,
    input  logic       lcd_rst,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_dc,
    output logic       frag_err,
    input  logic [8:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cur_x,
    output logic [2:0] cur_y,
    output logic       pd,
    output logic       v,
    output logic       h,
    output logic [1:0] disp_mode,
    output logic [6:0] vop,
    output logic       frame_done
);

    import lcd_pkg::*;

    localparam logic [6:0] LAST_X    = 7'(COLS - 1);
    localparam logic [2:0] LAST_Y    = 3'(ROWS - 1);
    localparam logic [8:0] LAST_ADDR = 9'(COLS * ROWS - 1);

    logic lcd_rst_sync;

    lcd_spi_deframer #(.SYNC_STAGES(SYNC_STAGES)) u_deframer (
        .clk          (clk),
        .reset        (reset),
        .mosi         (mosi),
        .sclk         (sclk),
        .ce           (ce),
        .dc           (dc),
        .lcd_rst      (lcd_rst),
        .byte_valid   (byte_valid),
        .byte_out     (byte_out),
        .byte_dc      (byte_dc),
        .frag_err     (frag_err),
        .lcd_rst_sync (lcd_rst_sync)
    );

    status_t    st;
    logic [8:0] wr_addr;
    logic       wr_en;

    assign wr_addr = {6'd0, st.y} * 9'(COLS) + {2'd0, st.x};
    assign wr_en   = byte_valid & byte_dc & lcd_rst_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!lcd_rst_sync) begin
                st    <= '0;
                st.pd <= 1'b1;
            end else if (byte_valid) begin
                if (byte_dc) begin
                    frame_done <= (wr_addr == LAST_ADDR);
                    // Address auto-increment; the minor axis carries into the major.
                    if (!st.v) begin
                        if (st.x == LAST_X) begin
                            st.x <= '0;
                            st.y <= (st.y == LAST_Y) ? 3'd0 : st.y + 3'd1;
                        end else begin
                            st.x <= st.x + 7'd1;
                        end
                    end else begin
                        if (st.y == LAST_Y) begin
                            st.y <= '0;
                            st.x <= (st.x == LAST_X) ? 7'd0 : st.x + 7'd1;
                        end else begin
                            st.y <= st.y + 3'd1;
                        end
                    end
                end else begin
                    if (op_match(byte_out, FUNC_SET_MASK, FUNC_SET_PAT)) begin
                        {st.pd, st.v, st.h} <= byte_out[2:0];
                    end else if (!st.h) begin
                        if (op_match(byte_out, DISP_CTRL_MASK, DISP_CTRL_PAT)) begin
                            st.disp_mode <= {byte_out[2], byte_out[0]};
                        end else if (op_match(byte_out, SET_Y_MASK, SET_Y_PAT)) begin
                            if ({1'b0, byte_out[2:0]} < 4'(ROWS)) st.y <= byte_out[2:0];
                        end else if (op_match(byte_out, SET_X_MASK, SET_X_PAT)) begin
                            if ({1'b0, byte_out[6:0]} < 8'(COLS)) st.x <= byte_out[6:0];
                        end
                    end else begin
                        // Extended set: temperature and bias codes carry no
                        // modelled state, so only Vop is kept.
                        if (op_match(byte_out, VOP_MASK, VOP_PAT)) st.vop <= byte_out[6:0];
                    end
                end
            end
        end
    end

    assign cur_x     = st.x;
    assign cur_y     = st.y;
    assign pd        = st.pd;
    assign v         = st.v;
    assign h         = st.h;
    assign disp_mode = st.disp_mode;
    assign vop       = st.vop;

    // Shadow RAM: contents are not reset; a same-cycle read sees the old byte.
    logic [7:0] mem [COLS*ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= byte_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_addr <= LAST_ADDR) ? mem[rd_addr] : 8'd0;
        end
    end

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Directed bench for lcd_spi_monitor: table of command/data bytes with the
// expected controller status after each, plus hand-written sequences for
// RAM readback, fragments, LCD reset and asynchronous reset.
module tb_lcd_spi_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mosi = 1'b0;
    logic       sclk = 1'b0;
    logic       ce = 1'b1;
    logic       dc = 1'b0;
    logic       lcd_rst = 1'b1;
    logic [8:0] rd_addr = 9'd0;

    logic       byte_valid, byte_dc, frag_err, frame_done;
    logic [7:0] byte_out, rd_data;
    logic [6:0] cur_x, vop;
    logic [2:0] cur_y;
    logic       pd, v, h;
    logic [1:0] disp_mode;

    lcd_spi_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .mosi       (mosi),
        .sclk       (sclk),
        .ce         (ce),
        .dc         (dc),
        .lcd_rst    (lcd_rst),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_dc    (byte_dc),
        .frag_err   (frag_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .pd         (pd),
        .v          (v),
        .h          (h),
        .disp_mode  (disp_mode),
        .vop        (vop),
        .frame_done (frame_done)
    );

    always #10 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Pulse counters sampled on the falling edge.
    int         n_bv = 0;
    int         n_fe = 0;
    int         n_fd = 0;
    logic [7:0] last_b = 8'd0;
    logic       last_dc = 1'b0;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_bv    <= n_bv + 1;
            last_b  <= byte_out;
            last_dc <= byte_dc;
        end
        if (frag_err)   n_fe <= n_fe + 1;
        if (frame_done) n_fd <= n_fd + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        mosi = b;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        @(negedge clk);
        ce = 1'b0;
        dc = d;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        repeat (4) @(negedge clk);
        ce = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic read_ram(input logic [8:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic check_status(input string tag, input int x, input int y,
                                input int hh, input int vv, input int p,
                                input int dm, input int vp);
        check({tag, ".x"},   int'(cur_x), x);
        check({tag, ".y"},   int'(cur_y), y);
        check({tag, ".h"},   int'(h), hh);
        check({tag, ".v"},   int'(v), vv);
        check({tag, ".pd"},  int'(pd), p);
        check({tag, ".dm"},  int'(disp_mode), dm);
        check({tag, ".vop"}, int'(vop), vp);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic [6:0] x;
        logic [2:0] y;
        logic       hh;
        logic       vv;
        logic       p;
        logic [1:0] dm;
        logic [6:0] vp;
        logic       fd;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        int         bv0, fe0, fd0;
        logic [7:0] rd;

        //              byte   dc    x      y     h     v     pd    dm     vop    fd
        tbl[0]  = '{8'h21, 1'b0, 7'd0,  3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'h00, 1'b0};
        tbl[1]  = '{8'hC8, 1'b0, 7'd0,  3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[2]  = '{8'h20, 1'b0, 7'd0,  3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[3]  = '{8'h42, 1'b0, 7'd0,  3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[4]  = '{8'h8A, 1'b0, 7'd10, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[5]  = '{8'hA5, 1'b1, 7'd11, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[6]  = '{8'h5A, 1'b1, 7'd12, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[7]  = '{8'hD3, 1'b0, 7'd83, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[8]  = '{8'h45, 1'b0, 7'd83, 3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[9]  = '{8'hFF, 1'b1, 7'd0,  3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 7'h48, 1'b1};
        tbl[10] = '{8'h22, 1'b0, 7'd0,  3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[11] = '{8'h80, 1'b0, 7'd0,  3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[12] = '{8'h45, 1'b0, 7'd0,  3'd5, 1'b0, 1'b1, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[13] = '{8'h3C, 1'b1, 7'd1,  3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[14] = '{8'hDA, 1'b0, 7'd1,  3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[15] = '{8'h47, 1'b0, 7'd1,  3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[16] = '{8'h21, 1'b0, 7'd1,  3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'h48, 1'b0};
        tbl[17] = '{8'hDA, 1'b0, 7'd1,  3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'h5A, 1'b0};
        tbl[18] = '{8'h20, 1'b0, 7'd1,  3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 7'h5A, 1'b0};
        tbl[19] = '{8'h0D, 1'b0, 7'd1,  3'd0, 1'b0, 1'b0, 1'b0, 2'd3, 7'h5A, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_status("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset.bv", int'(byte_valid), 0);
        check("reset.fe", int'(frag_err), 0);
        check("reset.fd", int'(frame_done), 0);
        check("reset.rd", int'(rd_data), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset.pd", int'(pd), 0);

        // Table: one byte per entry, status checked after each
        for (int i = 0; i < NV; i++) begin
            bv0 = n_bv;
            fd0 = n_fd;
            fe0 = n_fe;
            send_byte(tbl[i].b, tbl[i].d);
            check($sformatf("v%0d.bv_cnt", i), n_bv - bv0, 1);
            check($sformatf("v%0d.fe_cnt", i), n_fe - fe0, 0);
            check($sformatf("v%0d.byte", i), int'(last_b), int'(tbl[i].b));
            check($sformatf("v%0d.dc", i), int'(last_dc), int'(tbl[i].d));
            check($sformatf("v%0d.fd_cnt", i), n_fd - fd0, int'(tbl[i].fd));
            check_status($sformatf("v%0d", i), int'(tbl[i].x), int'(tbl[i].y),
                         int'(tbl[i].hh), int'(tbl[i].vv), int'(tbl[i].p),
                         int'(tbl[i].dm), int'(tbl[i].vp));
        end

        // Shadow RAM readback, including the out-of-range address
        read_ram(9'd178, rd); check("ram178", int'(rd), 'hA5);
        read_ram(9'd179, rd); check("ram179", int'(rd), 'h5A);
        read_ram(9'd503, rd); check("ram503", int'(rd), 'hFF);
        read_ram(9'd420, rd); check("ram420", int'(rd), 'h3C);
        read_ram(9'd504, rd); check("ram504", int'(rd), 0);
        read_ram(9'd511, rd); check("ram511", int'(rd), 0);

        // Fragment: 5 bits then ce high, then a clean byte
        bv0 = n_bv;
        fe0 = n_fe;
        @(negedge clk);
        ce = 1'b0;
        dc = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (4) @(negedge clk);
        ce = 1'b1;
        repeat (10) @(negedge clk);
        check("frag.fe_cnt", n_fe - fe0, 1);
        check("frag.bv_cnt", n_bv - bv0, 0);
        check("frag.dm_kept", int'(disp_mode), 3);
        send_byte(8'h0C, 1'b0);
        check("frag.next_bv", n_bv - bv0, 1);
        check("frag.next_byte", int'(last_b), 'h0C);
        check("frag.next_dm", int'(disp_mode), 2);
        check("frag.fe_total", n_fe - fe0, 1);

        // LCD reset mid-byte after x=30,y=3; 8th bit arrives while held
        send_byte(8'h9E, 1'b0);
        send_byte(8'h43, 1'b0);
        check_status("pre_lrst", 30, 3, 0, 0, 0, 2, 'h5A);
        bv0 = n_bv;
        fe0 = n_fe;
        @(negedge clk);
        ce = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        lcd_rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (4) @(negedge clk);
        check_status("lrst", 0, 0, 0, 0, 1, 0, 0);
        check("lrst.bv_cnt", n_bv - bv0, 0);
        lcd_rst = 1'b1;
        repeat (6) @(negedge clk);
        ce = 1'b1;
        repeat (8) @(negedge clk);
        check("lrst.fe_cnt", n_fe - fe0, 0);
        check("lrst.pd_held", int'(pd), 1);
        read_ram(9'd178, rd); check("lrst.ram178", int'(rd), 'hA5);
        read_ram(9'd420, rd); check("lrst.ram420", int'(rd), 'h3C);

        // Asynchronous reset mid-byte: outputs clear without a clock edge
        send_byte(8'h85, 1'b0);
        send_byte(8'h09, 1'b0);
        check_status("pre_arst", 5, 0, 0, 0, 1, 1, 0);
        check("pre_arst.rd", int'(rd_data), 'h3C);
        @(negedge clk);
        ce = 1'b0;
        send_bit(1'b1); send_bit(1'b1);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check_status("arst", 0, 0, 0, 0, 0, 0, 0);
        check("arst.rd", int'(rd_data), 0);
        check("arst.bv", int'(byte_valid), 0);
        check("arst.fe", int'(frag_err), 0);
        ce = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        bv0 = n_bv;
        fe0 = n_fe;
        send_byte(8'h21, 1'b0);
        check("arst.after_bv", n_bv - bv0, 1);
        check("arst.after_fe", n_fe - fe0, 0);
        check("arst.after_h", int'(h), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
